uart_envio_resposta: RTL and testbench

UART_ENVIO_RESPOSTA -- requirements
Module: uart_envio_resposta

---
 rtl/uart_envio_resposta_pkg.sv | 13 +
 rtl/uart_envio_resposta_baud_tick.sv | 18 +
 rtl/uart_envio_resposta.sv | 104 ++++++++++
 tb/tb_uart_envio_resposta.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_envio_resposta_pkg.sv
// uart_envio_resposta_pkg: shared FSM states, frame constants and response codes
package uart_envio_resposta_pkg;
  localparam int BYTE_W = 8;
  localparam int BITS_PER_FRAME_8N1 = 10;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;
  localparam logic [BYTE_W-1:0] RSP_07 = 8'h07;
  localparam logic [BYTE_W-1:0] RSP_08 = 8'h08;
  localparam logic [BYTE_W-1:0] RSP_09 = 8'h09;
  localparam logic [BYTE_W-1:0] RSP_1F = 8'h1F;
  localparam logic [BYTE_W-1:0] RSP_45 = 8'h45;
  localparam logic [BYTE_W-1:0] RSP_AA = 8'hAA;
  localparam logic [BYTE_W-1:0] RSP_FF = 8'hFF;
endpackage

// File: rtl/uart_envio_resposta_baud_tick.sv
// uart_baud_tick: CLKS_PER_BIT down-counter, tick marks the last cycle of each bit
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] RELOAD = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] cnt;
  assign tick = cnt == '0;
  // reload on restart or at every bit boundary so bit lengths never drift
  always_ff @(posedge clock or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= (restart || tick) ? RELOAD : cnt - 1'b1;
endmodule

// File: rtl/uart_envio_resposta.sv
// uart_envio_resposta: sends a command/value byte pair as two UART frames; define UART_TX_PARITY_EN for 8E1
module uart_envio_resposta
  import uart_envio_resposta_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int GAP_BITS = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dadosPodemSerEnviados,
  input  logic [BYTE_W-1:0] response_command,
  input  logic [BYTE_W-1:0] response_value,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic              overrun
);
  localparam logic [3:0] GAP_LAST = 4'(GAP_BITS - 1);
  state_t state;
  logic byte_idx;
  logic [3:0] bit_idx;
  logic [BYTE_W-1:0] cmd_q, val_q, cur;
  logic tick;
  assign cur = byte_idx ? val_q : cmd_q;
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clock  (clock),
    .reset  (reset),
    .restart(state == IDLE),
    .tick   (tick)
  );
  // frame sequencer; tx is registered and set for the state being entered
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      byte_idx <= 1'b0;
      bit_idx <= '0;
      cmd_q <= '0;
      val_q <= '0;
      tx <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done <= 1'b0;
      if (dadosPodemSerEnviados && (busy || done)) overrun <= 1'b1;
      case (state)
        IDLE: if (dadosPodemSerEnviados && !done) begin
          cmd_q <= response_command;
          val_q <= response_value;
          byte_idx <= 1'b0;
          bit_idx <= '0;
          busy <= 1'b1;
          overrun <= 1'b0;
          tx <= 1'b0;
          state <= START;
        end
        START: if (tick) begin
          bit_idx <= '0;
          tx <= cur[0];
          state <= DATA;
        end
        DATA: if (tick) begin
          if (bit_idx == 4'd7) begin
`ifdef UART_TX_PARITY_EN
            tx <= ^cur;
            state <= PARITY;
`else
            tx <= 1'b1;
            state <= STOP;
`endif
          end else begin
            bit_idx <= bit_idx + 1'b1;
            tx <= cur[bit_idx[2:0] + 3'd1];
          end
        end
        PARITY: if (tick) begin
          tx <= 1'b1;
          state <= STOP;
        end
        STOP: if (tick) begin
          if (!byte_idx) begin
            byte_idx <= 1'b1;
            tx <= 1'b0;
            state <= START;
          end else if (GAP_BITS == 0) begin
            busy <= 1'b0;
            done <= 1'b1;
            state <= IDLE;
          end else begin
            bit_idx <= '0;
            state <= GAP;
          end
        end
        GAP: if (tick) begin
          if (bit_idx == GAP_LAST) begin
            busy <= 1'b0;
            done <= 1'b1;
            state <= IDLE;
          end else bit_idx <= bit_idx + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_envio_resposta.sv
// tb_uart_envio_resposta: randomized and directed checks against a frame-level tx model
module tb_uart_envio_resposta;
  import uart_envio_resposta_pkg::*;
  localparam int CPB = 4;
  logic clock = 0, reset = 0, strobe = 0;
  logic [7:0] cmd = 0, val = 0;
  logic tx1, busy1, done1, ov1, tx0, busy0, done0, ov0;
  logic tx_s, busy_s, done_s, ov_s;
  bit sel = 0;
  int tests = 0, fails = 0;
  logic tx_a[0:255], done_a[0:255], busy_a[0:255], ov_a[0:255];
  bit exp_q[$];
  int exp_done;
  logic [7:0] codes[7];

  assign tx_s = sel ? tx0 : tx1;
  assign busy_s = sel ? busy0 : busy1;
  assign done_s = sel ? done0 : done1;
  assign ov_s = sel ? ov0 : ov1;

  always #5 clock = ~clock;

  uart_envio_resposta #(.CLKS_PER_BIT(CPB), .GAP_BITS(1)) dut (
    .clock(clock), .reset(reset), .dadosPodemSerEnviados(strobe),
    .response_command(cmd), .response_value(val),
    .tx(tx1), .busy(busy1), .done(done1), .overrun(ov1));

  uart_envio_resposta #(.CLKS_PER_BIT(CPB), .GAP_BITS(0)) dut0 (
    .clock(clock), .reset(reset), .dadosPodemSerEnviados(strobe),
    .response_command(cmd), .response_value(val),
    .tx(tx0), .busy(busy0), .done(done0), .overrun(ov0));

  // expected tx level for cycles 1..exp_done after the strobe cycle
  task automatic model_frame(input logic [7:0] c, input logic [7:0] v, input int gap);
    logic [7:0] b;
    exp_q.delete();
    for (int n = 0; n < 2; n++) begin
      b = (n == 1) ? v : c;
      repeat (CPB) exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) repeat (CPB) exp_q.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
      repeat (CPB) exp_q.push_back(^b);
`endif
      repeat (CPB) exp_q.push_back(1'b1);
    end
    repeat (gap * CPB) exp_q.push_back(1'b1);
    exp_done = exp_q.size() + 1;
    exp_q.push_back(1'b1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 0;
    strobe = 0;
    @(negedge clock);
    reset = 1;
  endtask

  // strobe in cycle 0, record cycles 1..n, optionally strobe again in cycle inj_k
  task automatic frame(input logic [7:0] c, input logic [7:0] v, input int n,
                       input int inj_k, input logic [7:0] ic, input logic [7:0] iv);
    cmd = c;
    val = v;
    strobe = 1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clock);
      tx_a[k] = tx_s;
      done_a[k] = done_s;
      busy_a[k] = busy_s;
      ov_a[k] = ov_s;
      strobe = (k == inj_k);
      if (k == inj_k) begin
        cmd = ic;
        val = iv;
      end
    end
  endtask

  function automatic int first_bad();
    for (int k = 1; k <= exp_done; k++)
      if (tx_a[k] !== logic'(exp_q[k-1])) return k;
    return 0;
  endfunction

  function automatic int first_done(input int n);
    for (int k = 1; k <= n; k++)
      if (done_a[k] === 1'b1) return k;
    return 0;
  endfunction

  task automatic test_reset();
    reset = 0;
    @(negedge clock);
    @(negedge clock);
    tests++; if (tx1 !== 1'b1) begin fails++; $display("FAIL reset_tx got %b exp 1", tx1); end
    tests++; if (busy1 !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy1); end
    tests++; if (done1 !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", done1); end
    tests++; if (ov1 !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b exp 0", ov1); end
    tests++; if (tx0 !== 1'b1) begin fails++; $display("FAIL reset_tx_gap0 got %b exp 1", tx0); end
    reset = 1;
  endtask

  task automatic test_spec_frame();
    int b, d;
    sel = 0;
    do_reset();
    model_frame(RSP_09, 8'h1A, 1);
    frame(RSP_09, 8'h1A, exp_done, -1, 8'h00, 8'h00);
    b = first_bad();
    d = first_done(exp_done);
    tests++; if (b != 0) begin fails++; $display("FAIL spec_wave cycle %0d got %b exp %b", b, tx_a[b], exp_q[b-1]); end
    tests++; if (d != exp_done) begin fails++; $display("FAIL spec_done_cycle got %0d exp %0d", d, exp_done); end
`ifndef UART_TX_PARITY_EN
    tests++; if (d != 85) begin fails++; $display("FAIL spec_done_85 got %0d exp 85", d); end
`endif
    tests++; if (busy_a[1] !== 1'b1) begin fails++; $display("FAIL spec_busy_set got %b exp 1", busy_a[1]); end
    tests++; if (busy_a[exp_done] !== 1'b0) begin fails++; $display("FAIL spec_busy_clr got %b exp 0", busy_a[exp_done]); end
    @(negedge clock);
    tests++; if (done_s !== 1'b0) begin fails++; $display("FAIL spec_done_pulse got %b exp 0", done_s); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int d;
    sel = 0;
    do_reset();
    model_frame(RSP_07, RSP_45, 1);
    frame(RSP_07, RSP_45, exp_done, -1, 8'h00, 8'h00);
    d = first_done(exp_done);
    tests++; if (d != 93) begin fails++; $display("FAIL parity_done got %0d exp 93", d); end
    tests++; if (tx_a[37] !== 1'b1 || tx_a[40] !== 1'b1) begin fails++; $display("FAIL parity_cmd got %b%b exp 11", tx_a[37], tx_a[40]); end
    tests++; if (tx_a[81] !== 1'b1 || tx_a[84] !== 1'b1) begin fails++; $display("FAIL parity_val got %b%b exp 11", tx_a[81], tx_a[84]); end
    tests++; if (first_bad() != 0) begin fails++; $display("FAIL parity_wave cycle %0d", first_bad()); end
    @(negedge clock);
  endtask
`endif

  task automatic test_overrun();
    int b;
    sel = 0;
    do_reset();
    model_frame(RSP_AA, RSP_1F, 1);
    frame(RSP_AA, RSP_1F, exp_done, 10, RSP_FF, RSP_08);
    b = first_bad();
    tests++; if (b != 0) begin fails++; $display("FAIL ovr_wave cycle %0d got %b exp %b", b, tx_a[b], exp_q[b-1]); end
    tests++; if (ov_a[11] !== 1'b1) begin fails++; $display("FAIL ovr_set got %b exp 1", ov_a[11]); end
    tests++; if (ov_a[exp_done] !== 1'b1) begin fails++; $display("FAIL ovr_sticky got %b exp 1", ov_a[exp_done]); end
    @(negedge clock);
    model_frame(RSP_45, RSP_07, 1);
    frame(RSP_45, RSP_07, exp_done, -1, 8'h00, 8'h00);
    b = first_bad();
    tests++; if (ov_a[1] !== 1'b0) begin fails++; $display("FAIL ovr_clear got %b exp 0", ov_a[1]); end
    tests++; if (b != 0) begin fails++; $display("FAIL ovr_next_wave cycle %0d got %b exp %b", b, tx_a[b], exp_q[b-1]); end
    @(negedge clock);
  endtask

  task automatic test_done_collision();
    int b;
    sel = 0;
    do_reset();
    model_frame(RSP_1F, RSP_AA, 1);
    frame(RSP_1F, RSP_AA, exp_done, exp_done, RSP_FF, RSP_FF);
    tests++; if (done_a[exp_done] !== 1'b1) begin fails++; $display("FAIL col_done got %b exp 1", done_a[exp_done]); end
    @(negedge clock);
    tests++; if (ov_s !== 1'b1) begin fails++; $display("FAIL col_overrun got %b exp 1", ov_s); end
    tests++; if (busy_s !== 1'b0 || tx_s !== 1'b1) begin fails++; $display("FAIL col_dropped busy %b tx %b exp 0 1", busy_s, tx_s); end
    model_frame(RSP_08, 8'h3C, 1);
    frame(RSP_08, 8'h3C, exp_done, -1, 8'h00, 8'h00);
    b = first_bad();
    tests++; if (tx_a[1] !== 1'b0) begin fails++; $display("FAIL col_start got %b exp 0", tx_a[1]); end
    tests++; if (b != 0) begin fails++; $display("FAIL col_wave cycle %0d got %b exp %b", b, tx_a[b], exp_q[b-1]); end
    tests++; if (ov_a[1] !== 1'b0) begin fails++; $display("FAIL col_ovr_clear got %b exp 0", ov_a[1]); end
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    int noisy = 0;
    sel = 0;
    do_reset();
    frame(RSP_FF, 8'h00, 58, -1, 8'h00, 8'h00);
    reset = 0;
    #1;
    tests++; if (tx_s !== 1'b1 || busy_s !== 1'b0) begin fails++; $display("FAIL rst_mid tx %b busy %b exp 1 0", tx_s, busy_s); end
    @(negedge clock);
    reset = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (tx_s !== 1'b1 || busy_s !== 1'b0 || done_s !== 1'b0) noisy++;
    end
    tests++; if (noisy != 0) begin fails++; $display("FAIL rst_quiet got %0d active cycles exp 0", noisy); end
  endtask

  task automatic test_gap0();
    int b, d;
    sel = 1;
    do_reset();
    model_frame(RSP_AA, RSP_45, 0);
    frame(RSP_AA, RSP_45, exp_done, -1, 8'h00, 8'h00);
    b = first_bad();
    d = first_done(exp_done);
    tests++; if (b != 0) begin fails++; $display("FAIL gap0_wave cycle %0d got %b exp %b", b, tx_a[b], exp_q[b-1]); end
    tests++; if (d != exp_done) begin fails++; $display("FAIL gap0_done got %0d exp %0d", d, exp_done); end
`ifndef UART_TX_PARITY_EN
    tests++; if (d != 81) begin fails++; $display("FAIL gap0_done_81 got %0d exp 81", d); end
`endif
    @(negedge clock);
    tests++; if (tx_s !== 1'b1 || busy_s !== 1'b0) begin fails++; $display("FAIL gap0_idle tx %b busy %b exp 1 0", tx_s, busy_s); end
    model_frame(RSP_09, RSP_1F, 0);
    frame(RSP_09, RSP_1F, exp_done, -1, 8'h00, 8'h00);
    b = first_bad();
    tests++; if (b != 0) begin fails++; $display("FAIL gap0_b2b_wave cycle %0d got %b exp %b", b, tx_a[b], exp_q[b-1]); end
    @(negedge clock);
    sel = 0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] c, v;
    int b, d;
    sel = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      c = (i < 4) ? codes[$urandom_range(0, 6)] : 8'($urandom);
      v = 8'($urandom);
      model_frame(c, v, 1);
      frame(c, v, exp_done, -1, 8'h00, 8'h00);
      b = first_bad();
      d = first_done(exp_done);
      tests++; if (b != 0) begin fails++; $display("FAIL rand_wave %0d c %h v %h cycle %0d got %b exp %b", i, c, v, b, tx_a[b], exp_q[b-1]); end
      tests++; if (d != exp_done) begin fails++; $display("FAIL rand_done %0d got %0d exp %0d", i, d, exp_done); end
      @(negedge clock);
    end
  endtask

  initial begin
    codes = '{RSP_07, RSP_08, RSP_09, RSP_1F, RSP_45, RSP_AA, RSP_FF};
    test_reset();
    test_spec_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_overrun();
    test_done_collision();
    test_reset_mid();
    test_gap0();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
